// File: rtl/sub_bytes_seq.sv
// Iterative forward AES SubBytes engine: substitutes LANES bytes of a 128-bit
// state per clock using LANES copies of the FIPS-197 forward S-box.
// Valid/ready handshakes on input and output; byte 0 is the state MSB.
module sub_bytes_seq #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  localparam int unsigned NGRP = 16 / LANES;
  localparam int unsigned GW   = (NGRP > 1) ? $clog2(NGRP) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  // Forward S-box, entry 0 in the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grp_q, grp_d;
  logic [127:0]    work_q, work_d;

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    return SBOX[x];
  endfunction

  // State, group counter and work register; reset clears all of them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grp_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      work_q  <= work_d;
    end
  end

  // Next-state logic, in-place group substitution and handshake outputs.
  always_comb begin
    int unsigned base;
    int unsigned pos;
    logic [6:0]  lsb;
    state_d   = state_q;
    grp_d     = grp_q;
    work_d    = work_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    base      = 32'(grp_q) * LANES;
    pos       = 0;
    lsb       = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = state_in;
          grp_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        // Byte i sits at bits [127-8i -: 8]; lane l handles byte grp*LANES+l.
        for (int unsigned l = 0; l < LANES; l++) begin
          pos = base + l;
          lsb = 7'(120 - 8 * pos);
          work_d[lsb +: 8] = sbox_fwd(work_q[lsb +: 8]);
        end
        if (grp_q == GW'(NGRP - 1)) begin
          grp_d   = '0;
          state_d = DONE;
        end else begin
          grp_d = grp_q + 1'b1;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign state_out = work_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench for sub_bytes_seq: five instances with LANES = 4, 16, 1, 2, 8
// share one clock. Reference S-box is derived from GF(2^8) inversion + affine map.
module tb_sub_bytes_seq;

  logic               clk;
  logic [4:0]         rst;
  logic [4:0]         in_valid;
  logic [4:0]         in_ready;
  logic [4:0][127:0]  state_in;
  logic [4:0]         out_valid;
  logic [4:0]         out_ready;
  logic [4:0][127:0]  state_out;
  logic [4:0]         busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] ref_tab [256];
  logic [7:0] inv_tab [256];

  localparam logic [127:0] VEC_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] VEC_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 4 : (g == 1) ? 16 : (g == 2) ? 1 : (g == 3) ? 2 : 8;
    sub_bytes_seq #(.LANES(L)) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .state_in  (state_in[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .state_out (state_out[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = '0;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] x, input int n);
    logic [7:0] r = x;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] b = '0;
    if (x != 8'h00) begin
      for (int y = 1; y < 256; y++) begin
        if (gmul(x, 8'(y)) == 8'h01) b = 8'(y);
      end
    end
    return b ^ rol8(b, 1) ^ rol8(b, 2) ^ rol8(b, 3) ^ rol8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_state_ref(input logic [127:0] s);
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = ref_tab[s[127-8*i -: 8]];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one block into DUT d (assumed IDLE), wait for out_valid, then release it.
  task automatic run_block(input int d, input logic [127:0] s, output int lat,
                           output logic [127:0] res);
    int n;
    in_valid[d]  = 1'b1;
    state_in[d]  = s;
    out_ready[d] = 1'b1;
    step();
    in_valid[d] = 1'b0;
    n   = 0;
    lat = -1;
    while (n < 40 && lat < 0) begin
      step();
      n++;
      if (out_valid[d]) lat = n;
    end
    res = state_out[d];
    step();
  endtask

  initial begin
    int           lat;
    int           n;
    logic [127:0] res;
    logic [127:0] s;
    logic [127:0] c_exp;
    logic         seen;
    int           cyc;
    int           nacc;
    int           nres;
    logic         acc_now;
    int           acc_cyc [4];
    logic [127:0] blk [4];
    logic [127:0] outs [4];

    for (int x = 0; x < 256; x++) ref_tab[x] = sbox_ref(8'(x));
    for (int x = 0; x < 256; x++) inv_tab[ref_tab[x]] = 8'(x);

    rst       = '1;
    in_valid  = '0;
    out_ready = '1;
    state_in  = '0;
    step();
    step();

    // Reset state (observed while reset is still held)
    chk("rst_out_valid", 128'(out_valid[0]), 128'(0));
    chk("rst_in_ready",  128'(in_ready[0]),  128'(1));
    chk("rst_busy",      128'(busy[0]),      128'(0));
    chk("rst_state_out", state_out[0],       128'h0);
    rst = '0;

    // App. B vector, LANES=4
    run_block(0, VEC_IN, lat, res);
    chk("l4_latency", 128'(lat), 128'(4));
    chk("l4_result",  res,       VEC_OUT);
    chk("l4_idle_in_ready", 128'(in_ready[0]), 128'(1));
    chk("l4_idle_busy",     128'(busy[0]),     128'(0));

    // Full table sweep, LANES=16
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = 8'(16 * k + i);
      run_block(1, s, lat, res);
      chk("l16_latency", 128'(lat), 128'(1));
      for (int i = 0; i < 16; i++) begin
        chk("sbox_byte", 128'(res[127-8*i -: 8]), 128'(ref_tab[16 * k + i]));
        chk("inv_roundtrip", 128'(inv_tab[res[127-8*i -: 8]]), 128'(16 * k + i));
      end
      if (k == 0)  chk("sbox_00", 128'(res[127:120]), 128'h63);
      if (k == 5)  chk("sbox_53", 128'(res[127-8*3 -: 8]), 128'hed);
      if (k == 5)  chk("sbox_52", 128'(res[127-8*2 -: 8]), 128'h00);
      if (k == 15) chk("sbox_ff", 128'(res[7:0]), 128'h16);
    end

    // Backpressure with a competing input held valid, LANES=4
    c_exp          = sub_state_ref(VEC_OUT);
    out_ready[0]   = 1'b0;
    in_valid[0]    = 1'b1;
    state_in[0]    = VEC_IN;
    step();
    state_in[0] = VEC_OUT;
    n = 0;
    while (n < 40 && !out_valid[0]) begin
      step();
      n++;
    end
    chk("bp_latency", 128'(n), 128'(4));
    for (int i = 0; i < 10; i++) begin
      chk("bp_state_out", state_out[0], VEC_OUT);
      chk("bp_in_ready",  128'(in_ready[0]),  128'(0));
      chk("bp_out_valid", 128'(out_valid[0]), 128'(1));
      step();
    end
    out_ready[0] = 1'b1;
    step();
    chk("bp_back_idle", 128'(in_ready[0]), 128'(1));
    chk("bp_idle_busy", 128'(busy[0]),     128'(0));
    step();
    chk("bp_second_accepted", 128'(busy[0]), 128'(1));
    in_valid[0] = 1'b0;
    n = 0;
    while (n < 40 && !out_valid[0]) begin
      step();
      n++;
    end
    chk("bp2_latency", 128'(n), 128'(4));
    chk("bp2_result",  state_out[0], c_exp);
    step();

    // Reset in the 7th BUSY cycle, LANES=1
    in_valid[2] = 1'b1;
    state_in[2] = VEC_IN;
    step();
    in_valid[2] = 1'b0;
    repeat (6) step();
    chk("mid_busy_before_rst", 128'(busy[2]), 128'(1));
    rst[2] = 1'b1;
    step();
    rst[2] = 1'b0;
    chk("mid_rst_out_valid", 128'(out_valid[2]), 128'(0));
    chk("mid_rst_in_ready",  128'(in_ready[2]),  128'(1));
    chk("mid_rst_busy",      128'(busy[2]),      128'(0));
    chk("mid_rst_state_out", state_out[2],       128'h0);
    seen = 1'b0;
    repeat (20) begin
      step();
      if (out_valid[2]) seen = 1'b1;
    end
    chk("mid_rst_no_output", 128'(seen), 128'(0));

    // Parameter sweep with the App. B vector
    run_block(2, VEC_IN, lat, res);
    chk("l1_latency", 128'(lat), 128'(16));
    chk("l1_result",  res,       VEC_OUT);
    run_block(3, VEC_IN, lat, res);
    chk("l2_latency", 128'(lat), 128'(8));
    chk("l2_result",  res,       VEC_OUT);
    run_block(4, VEC_IN, lat, res);
    chk("l8_latency", 128'(lat), 128'(2));
    chk("l8_result",  res,       VEC_OUT);

    // Back-to-back throughput, LANES=4
    blk[0] = VEC_IN;
    blk[1] = 128'h000102030405060708090a0b0c0d0e0f;
    blk[2] = 128'h0;
    blk[3] = 128'hffeeddccbbaa99887766554433221100;
    cyc  = 0;
    nacc = 0;
    nres = 0;
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    state_in[0]  = blk[0];
    while (nres < 4 && cyc < 100) begin
      acc_now = in_ready[0] && in_valid[0];
      step();
      cyc++;
      if (acc_now) begin
        acc_cyc[nacc] = cyc;
        nacc++;
        if (nacc < 4) state_in[0] = blk[nacc];
        else in_valid[0] = 1'b0;
      end
      if (out_valid[0]) begin
        outs[nres] = state_out[0];
        nres++;
      end
    end
    in_valid[0] = 1'b0;
    chk("b2b_result_count", 128'(nres), 128'(4));
    chk("b2b_accept_count", 128'(nacc), 128'(4));
    for (int i = 1; i < 4; i++) chk("b2b_spacing", 128'(acc_cyc[i] - acc_cyc[i-1]), 128'(6));
    chk("b2b_res0", outs[0], VEC_OUT);
    for (int i = 1; i < 4; i++) chk("b2b_res", outs[i], sub_state_ref(blk[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
